// File: rtl/cholesky_inv_gram_mac_pkg.sv
// Shared parameters, FSM encoding and output rounding for the Gram-product stage
// of the 8x8 Cholesky-based complex inverse.
package cholesky_inv_gram_mac_pkg;

  localparam int N         = 8;
  localparam int DATA_W    = 32;
  localparam int FRAC_BITS = 16;
  localparam int ACC_W     = 72;
  localparam int BUS_W     = N * N * DATA_W;
  localparam int PROD_W    = 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_WRITE
  } state_t;

  localparam logic signed [ACC_W-1:0] ROUND_C =
    {{(ACC_W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Round half-up back to the Q format, then clamp to the signed DATA_W range.
  function automatic logic signed [DATA_W-1:0] sat_round_shift(
    input logic signed [ACC_W-1:0] v
  );
    logic signed [ACC_W-1:0] r;
    r = (v + ROUND_C) >>> FRAC_BITS;
    if (r > SAT_MAX) begin
      return SAT_MAX[DATA_W-1:0];
    end else if (r < SAT_MIN) begin
      return SAT_MIN[DATA_W-1:0];
    end
    return r[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/cholesky_inv_gram_mac_cplx_conj_mac.sv
// Complex conj(a)*b with a registered accumulator; shared with the upstream
// triangular-inversion stage.
module cholesky_inv_gram_mac_cplx_conj_mac
  import cholesky_inv_gram_mac_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  output logic signed [ACC_W-1:0]  acc_re,
  output logic signed [ACC_W-1:0]  acc_im
);

  logic signed [PROD_W-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [ACC_W-1:0]  prod_re, prod_im;

  assign p_rr = PROD_W'(a_re) * PROD_W'(b_re);
  assign p_ii = PROD_W'(a_im) * PROD_W'(b_im);
  assign p_ri = PROD_W'(a_re) * PROD_W'(b_im);
  assign p_ir = PROD_W'(a_im) * PROD_W'(b_re);

  // Conjugating a flips the sign of its imaginary part in both terms.
  assign prod_re = ACC_W'(p_rr) + ACC_W'(p_ii);
  assign prod_im = ACC_W'(p_ri) - ACC_W'(p_ir);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (en) begin
      acc_re <= acc_re + prod_re;
      acc_im <= acc_im + prod_im;
    end
  end

endmodule

// File: rtl/cholesky_inv_gram_mac.sv
// A_inv = L^H * L using one time-shared complex MAC; only k >= max(i,j)
// contributes because both factors are triangular.
module cholesky_inv_gram_mac
  import cholesky_inv_gram_mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [BUS_W-1:0] T_real_in,
  input  logic [BUS_W-1:0] T_imag_in,
  input  logic [BUS_W-1:0] L_real_in,
  input  logic [BUS_W-1:0] L_imag_in,
  output logic             in_ready,
  output logic             busy,
  output logic [BUS_W-1:0] A_inv_real_out,
  output logic [BUS_W-1:0] A_inv_imag_out,
  output logic             out_valid,
  output logic             overrun
);

  state_t state_reg;
  logic [2:0] i_reg, j_reg, k_reg;
  logic [2:0] i_next, j_next;

  logic signed [DATA_W-1:0] t_re_in [N*N];
  logic signed [DATA_W-1:0] t_im_in [N*N];
  logic signed [DATA_W-1:0] l_re_in [N*N];
  logic signed [DATA_W-1:0] l_im_in [N*N];

  logic signed [DATA_W-1:0] t_re_reg [N*N];
  logic signed [DATA_W-1:0] t_im_reg [N*N];
  logic signed [DATA_W-1:0] l_re_reg [N*N];
  logic signed [DATA_W-1:0] l_im_reg [N*N];
  logic signed [DATA_W-1:0] res_re_reg [N*N];
  logic signed [DATA_W-1:0] res_im_reg [N*N];

  logic signed [ACC_W-1:0] acc_re, acc_im;
  logic accept, mac_clr, mac_en;

  genvar gi;
  generate
    for (gi = 0; gi < N*N; gi++) begin : g_unpack
      assign t_re_in[gi] = T_real_in[gi*DATA_W +: DATA_W];
      assign t_im_in[gi] = T_imag_in[gi*DATA_W +: DATA_W];
      assign l_re_in[gi] = L_real_in[gi*DATA_W +: DATA_W];
      assign l_im_in[gi] = L_imag_in[gi*DATA_W +: DATA_W];
      assign A_inv_real_out[gi*DATA_W +: DATA_W] = res_re_reg[gi];
      assign A_inv_imag_out[gi*DATA_W +: DATA_W] = res_im_reg[gi];
    end
  endgenerate

  function automatic logic [2:0] max_idx(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? a : b;
  endfunction

  assign in_ready = !busy;
  assign accept   = (state_reg == ST_IDLE) && in_valid;
  assign mac_clr  = accept || (state_reg == ST_WRITE);
  assign mac_en   = (state_reg == ST_MAC);
  assign j_next   = j_reg + 3'd1;
  assign i_next   = (j_reg == 3'd7) ? i_reg + 3'd1 : i_reg;

  cholesky_inv_gram_mac_cplx_conj_mac u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (mac_clr),
    .en     (mac_en),
    .a_re   (t_re_reg[{i_reg, k_reg}]),
    .a_im   (t_im_reg[{i_reg, k_reg}]),
    .b_re   (l_re_reg[{k_reg, j_reg}]),
    .b_im   (l_im_reg[{k_reg, j_reg}]),
    .acc_re (acc_re),
    .acc_im (acc_im)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      for (int e = 0; e < N*N; e++) begin
        t_re_reg[e]   <= '0;
        t_im_reg[e]   <= '0;
        l_re_reg[e]   <= '0;
        l_im_reg[e]   <= '0;
        res_re_reg[e] <= '0;
        res_im_reg[e] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      // busy is the registered flag, so a request on the finishing edge is also dropped
      overrun   <= in_valid && busy;
      case (state_reg)
        ST_IDLE: begin
          if (in_valid) begin
            for (int e = 0; e < N*N; e++) begin
              t_re_reg[e] <= t_re_in[e];
              t_im_reg[e] <= t_im_in[e];
              l_re_reg[e] <= l_re_in[e];
              l_im_reg[e] <= l_im_in[e];
            end
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            busy      <= 1'b1;
            state_reg <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (k_reg == 3'd7) begin
            state_reg <= ST_WRITE;
          end else begin
            k_reg <= k_reg + 3'd1;
          end
        end
        ST_WRITE: begin
          res_re_reg[{i_reg, j_reg}] <= sat_round_shift(acc_re);
          res_im_reg[{i_reg, j_reg}] <= sat_round_shift(acc_im);
          if (i_reg == 3'd7 && j_reg == 3'd7) begin
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            i_reg     <= i_next;
            j_reg     <= j_next;
            k_reg     <= max_idx(i_next, j_next);
            state_reg <= ST_MAC;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
